// File: rtl/instr_mem_server.sv
// Instruction memory server: loads a program word-by-word over a
// valid/ready stream, then serves registered instruction fetches to a core
// while holding the core in reset until a valid program is present.
module instr_mem_server #(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [31:0]                    pc,
  output logic [31:0]                    instruction,
  output logic                           core_reset,
  input  logic                           load_start,
  input  logic                           load_valid,
  input  logic [31:0]                    load_data,
  input  logic                           load_last,
  output logic                           load_ready,
  output logic [$clog2(DEPTH_WORDS):0]   load_count,
  output logic                           fault
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [AW-1:0] wr_ptr;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          accept;
  logic          enter_load;
  logic          do_fetch;
  logic [AW-1:0] fetch_idx;
  logic          misaligned;
  logic          out_of_range;
  logic          unloaded;
  logic          fetch_bad;

  // A load word is taken only while the block is in LOAD and the source offers one.
  assign accept     = (state == LOAD) && load_valid;
  // Any transition into LOAD (from IDLE or by abandoning RUN) restarts the load.
  assign enter_load = (state_next == LOAD) && (state != LOAD);
  // A fetch is served only on edges that keep the block in RUN; an abandoning
  // load_start yields NOP so the core never sees a stale word while in reset.
  assign do_fetch   = (state == RUN) && (state_next == RUN);

  assign fetch_idx    = pc[AW+1:2];
  assign misaligned   = |pc[1:0];
  // Out-of-range addresses must not alias into the array, so check the high bits.
  assign out_of_range = |pc[31:AW+2];
  assign unloaded     = {1'b0, fetch_idx} >= load_count;
  assign fetch_bad    = misaligned || out_of_range || unloaded;

  // Next-state and load_ready decode.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_next = state;
    load_ready = 1'b0;
    unique case (state)
      IDLE: if (load_start) state_next = LOAD;
      LOAD: begin
        load_ready = 1'b1;
        if (accept && (load_last || (wr_ptr == AW'(DEPTH_WORDS - 1))))
          state_next = RUN;
      end
      RUN:  if (load_start) state_next = LOAD;
      default: state_next = IDLE;
    endcase
  end

  // State register; core_reset is a flop decoded from the next state so it is glitch-free.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state      <= IDLE;
      core_reset <= 1'b1;
    end else begin
      state      <= state_next;
      core_reset <= (state_next != RUN);
    end
  end

  // Write pointer and loaded-word count, cleared on each LOAD entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      load_count <= '0;
    end else if (enter_load) begin
      wr_ptr     <= '0;
      load_count <= '0;
    end else if (accept) begin
      wr_ptr     <= wr_ptr + AW'(1);
      load_count <= load_count + (AW+1)'(1);
    end
  end

  // Sticky fault flag: set by any bad fetch in RUN, cleared by reset or LOAD entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       fault <= 1'b0;
    else if (enter_load)             fault <= 1'b0;
    else if (do_fetch && fetch_bad)  fault <= 1'b1;
  end

  // Registered fetch data: one-cycle read latency, NOP whenever the fetch is not served.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       instruction <= NOP_WORD;
    else if (do_fetch && !fetch_bad) instruction <= mem[fetch_idx];
    else                             instruction <= NOP_WORD;
  end

  // Program storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; load_count masks stale contents and a reset-free array maps onto block RAM.
    if (accept) mem[wr_ptr] <= load_data;
  end

endmodule

// File: doc/instr_mem_server.md
INSTR_MEM_SERVER -- requirements
Module: instr_mem_server

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit instruction words stored (power of two, 4..4096).
REQ-002 SHALL have parameter NOP_WORD, default 32'h00000013 (addi x0,x0,0), word returned for any invalid or unloaded fetch.
REQ-003 SHALL have port clk, input, 1, clock.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have port pc, input, 32, byte fetch address driven by the core.
REQ-006 SHALL have port instruction, output, 32, registered fetch data to the core.
REQ-007 SHALL have port core_reset, output, 1, high holds the core in reset while no valid program is present.
REQ-008 SHALL have port load_start, input, 1, one-cycle request to begin a program load.
REQ-009 SHALL have port load_valid, input, 1, load_data is valid this cycle.
REQ-010 SHALL have port load_data, input, 32, program word to store.
REQ-011 SHALL have port load_last, input, 1, qualifies load_data as the final program word.
REQ-012 SHALL have port load_ready, output, 1, the block accepts a load word this cycle.
REQ-013 SHALL have port load_count, output, clog2(DEPTH_WORDS)+1, number of words loaded.
REQ-014 SHALL have port fault, output, 1, sticky flag for misaligned, out-of-range or unloaded fetch in RUN.

Function
REQ-015 SHALL implement states IDLE, LOAD and RUN.
REQ-016 IDLE: load_start -> LOAD next cycle; otherwise stay in IDLE.
REQ-017 LOAD entry SHALL clear the write pointer, load_count and fault.
REQ-018 LOAD: load_ready=1 combinationally; accept a word only when load_valid and load_ready are both 1.
REQ-019 On acceptance SHALL write load_data to mem[write pointer], then increment the write pointer and load_count.
REQ-020 Acceptance with load_last=1 SHALL move the FSM to RUN on the next cycle.
REQ-021 Acceptance into index DEPTH_WORDS-1 SHALL move the FSM to RUN regardless of load_last (full condition).
REQ-022 load_ready SHALL be 0 in IDLE and RUN.
REQ-023 load_valid and load_last outside LOAD SHALL be ignored; load_last without load_valid SHALL be ignored.
REQ-024 load_start during LOAD SHALL be ignored.
REQ-025 load_start during RUN SHALL enter LOAD next cycle and abandon the running program.
REQ-026 core_reset SHALL be 1 in IDLE and LOAD and 0 in RUN, registered from the state so there are no glitches.
REQ-027 In RUN, at each clk edge instruction SHALL be set to mem[pc[AW+1:2]], where AW = clog2(DEPTH_WORDS), so read latency is 1 cycle.
REQ-028 A fetch SHALL return NOP_WORD and set fault if pc[1:0] != 0.
REQ-029 A fetch SHALL return NOP_WORD and set fault if pc >= 4*DEPTH_WORDS; the address SHALL NOT wrap.
REQ-030 A fetch SHALL return NOP_WORD and set fault if its word index >= load_count.
REQ-031 In IDLE and LOAD, instruction SHALL be NOP_WORD on every edge.
REQ-032 fault SHALL stay set until reset or the next LOAD entry.
REQ-033 Memory contents SHALL persist across LOAD entries; only indices < load_count are valid.

Reset
REQ-034 Asynchronous reset SHALL force the following: state=IDLE, instruction=NOP_WORD, core_reset=1, load_ready=0, load_count=0, fault=0, write pointer=0.
REQ-035 Memory array SHALL NOT be reset; load_count=0 masks its contents.
REQ-036 Reset asserted mid-LOAD SHALL discard the partial load, leaving load_count=0 after release.

Verification
REQ-037 Reset, then pc=0 for 3 cycles -> instruction=0x00000013, core_reset=1, fault=0.
REQ-038 load_start, then words 0x00500093, 0x00108113 (load_last on the 2nd) -> load_count=2, RUN, core_reset=0; pc=4 -> instruction=0x00108113 on the next edge.
REQ-039 In RUN with load_count=2, pc=8 -> NOP, fault=1; pc=0x2 -> NOP, fault stays 1.
REQ-040 With DEPTH_WORDS=4, stream 4 words with load_last=0 -> RUN after the 4th word, load_ready=0; pc=0x10 -> NOP, fault=1.
REQ-041 load_valid held with load_ready toggling via stalls, and reset asserted after 1 accepted word -> IDLE, load_count=0, instruction=NOP.
REQ-042 In RUN, load_start -> core_reset=1 the next cycle, fault cleared, instruction=NOP until the new load ends.
